control_ram_arb: RTL and testbench
==================================

// Module: control_ram_arb
// PURPOSE
//  Multi-channel single-port RAM controller; successor to the single-channel control RAM.
//  NUM_CH requesters share one DEPTH x DATA_WIDTH array through a round-robin arbiter.
//  Each request uses a valid/ready handshake. Writes support byte enables.
//  Reads return a registered response one cycle after grant.
//  Out-of-range addresses are flagged, not aliased. Sits between bus masters and on-chip storage.
// PARAMETERS
//  DATA_WIDTH  8    word width in bits; must be a multiple of 8
//  ADDR_WIDTH  32   request address width (word address)
//  DEPTH       256  number of words implemented; must be <= 2**ADDR_WIDTH
//  NUM_CH      2    number of requesting channels, >= 1
// PORTS
//  clk        in   1                    clock, rising edge
//  reset      in   1                    asynchronous active-high reset
//  req_valid  in   NUM_CH               per-channel request valid
//  req_ready  out  NUM_CH               per-channel grant (combinational, one-hot or zero)
//  req_write  in   NUM_CH               1 = write, 0 = read
//  req_addr   in   NUM_CH*ADDR_WIDTH    channel c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata  in   NUM_CH*DATA_WIDTH    write data, packed per channel
//  req_be     in   NUM_CH*DATA_WIDTH/8  byte enables, packed per channel
//  rsp_valid  out  NUM_CH               read response strobe for channel c
//  rsp_data   out  DATA_WIDTH           read data, valid when any rsp_valid bit is set
//  rsp_err    out  1                    high with rsp_valid if the read address was >= DEPTH
//  wr_err     out  1                    one-cycle pulse the cycle after an out-of-range write is granted
// BEHAVIOUR
//  - Reset values: rsp_valid=0, rsp_data=0, rsp_err=0, wr_err=0, RR pointer=0.
//    Array contents are not reset.
//  - Arbitration: each cycle, grant the first valid channel searching from ptr, ptr+1, ... mod NUM_CH.
//    req_ready[g]=1 for that channel only. A transfer occurs when valid & ready.
//    After a transfer by channel g, ptr <= (g+1) mod NUM_CH. With no request, ptr is unchanged.
//  - No request is lost: an un-granted channel holds valid and its payload stable until ready.
//  - Write:
//    - A granted write with addr < DEPTH updates byte lane i at the clock edge iff be[i]=1.
//    - be=0 is a legal no-op.
//    - No response is issued for writes.
//  - Read: a granted read at edge N drives rsp_valid[g]=1 and rsp_data=mem[addr] during cycle N+1.
//    rsp_valid is a single-cycle pulse with no backpressure; throughput is one op per cycle.
//  - Back-to-back write then read of the same address (consecutive cycles) returns the new data.
//  - Out of range (addr >= DEPTH):
//    - Write: dropped; wr_err pulses.
//    - Read: rsp_valid pulses, rsp_data=0, rsp_err=1.
//  - Idle cycles: rsp_data holds its last value; rsp_err=0.
//  - Reset mid-operation: an in-flight read response is discarded.
//    Outputs and ptr return to reset values asynchronously. Memory keeps its contents.
//  - Widths: addr is compared at full ADDR_WIDTH (no truncation before the range check).
//    The index into the array is $clog2(DEPTH) bits.
// STRUCTURE
//  - control_ram_pkg:
//    - localparams for BE_WIDTH = DATA_WIDTH/8 and IDX_WIDTH = $clog2(DEPTH)
//    - typedef of the request struct {write, addr, wdata, be}
//    - function for channel slice extraction
//  - Sub-module rr_arbiter #(NUM_CH): req -> one-hot grant + pointer register.
//    It is reused by the other arbitrated blocks.
//  - Top level: unpack, arbiter, request mux, range check, byte-masked array write, registered read stage.
// TESTING (DATA_WIDTH=8, DEPTH=256, NUM_CH=2 unless stated)
//  1. Reset high 100 ns, then ch0 write addr 0x00 data 0x5A be=1, then ch0 read addr 0x00
//     -> rsp_valid[0]=1 one cycle after grant, rsp_data=0x5A, rsp_err=0.
//  2. ch0 and ch1 both hold valid reads every cycle for 6 cycles
//     -> grants alternate 0,1,0,1,0,1; each rsp_valid bit pulses 3 times; no grant is lost.
//  3. DATA_WIDTH=32: write 0xAABBCCDD be=4'b1111, then write 0x11223344 be=4'b0101 to the same address, then read
//     -> 0xAA22CC44.
//  4. ch1 read addr 0x100 -> rsp_valid[1]=1, rsp_data=0, rsp_err=1.
//     ch1 write addr 0x1FF -> wr_err pulses; array is unchanged (read back of 0xFF is unaffected).
//  5. Grant a read, assert reset in the response cycle -> rsp_valid drops immediately, ptr=0.
//     Read back of data written earlier still matches.
//  6. NUM_CH=3, all valid, ch1 drops after its grant -> sequence 0,1,2,0,2,0.
//     Payload is held stable while a channel waits.

Source files
------------

// File: rtl/control_ram_arb_pkg.sv
// Shared types and width helpers for the arbitrated control RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package control_ram_arb_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // Array index width; a one-word array still needs a 1-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ptr_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Low bit of channel ch inside a bus that packs w bits per channel.
    function automatic int slice_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/control_ram_arb_if.sv
// Request/response bundle between bus masters and the arbitrated RAM.
// Latency: n/a (wires only).
// Backpressure: req_ready per channel, responses have none.
interface control_ram_arb_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH-1:0]            req_write;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CH*BE_W-1:0]       req_be;
    logic [NUM_CH-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]        rsp_data;
    logic                         rsp_err;
    logic                         wr_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_data, rsp_err, wr_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_data, rsp_err, wr_err
    );

endinterface

// File: rtl/control_ram_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer advances on the edge after a grant.
// Backpressure: a request simply waits until it is granted.
module rr_arbiter
    import control_ram_arb_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt
);
    localparam int PW = ptr_width(NUM_CH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] cand;
    logic          found;

    function automatic int wrap(input int p, input int i);
        return (p + i) % NUM_CH;
    endfunction

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        cand    = '0;
        ptr_nxt = ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = PW'(wrap(int'(ptr_q), i));
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                ptr_nxt   = (int'(cand) == NUM_CH - 1) ? '0 : cand + 1'b1;
            end
        end
    end

    // Every grant is a transfer (ready only goes to a valid channel).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/control_ram_arb.sv
// Multi-channel single-port RAM with round-robin access and byte-enabled writes.
// Latency: writes land at the grant edge; read data is registered, valid the cycle after grant.
// Backpressure: per-channel req_ready from the arbiter; responses are unthrottled pulses.
module control_ram_arb
    import control_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int NUM_CH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    control_ram_arb_if.slave     bus
);
    localparam int BE_W  = be_width(DATA_WIDTH);
    localparam int IDX_W = idx_width(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef struct packed {
        op_e                   op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } req_t;

    req_t                  req [NUM_CH];
    req_t                  sel;
    logic [NUM_CH-1:0]     gnt;
    logic                  fire;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NUM_CH-1:0]     rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;
    logic                  wr_err_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            req[c].op    = op_e'(bus.req_write[c]);
            req[c].addr  = bus.req_addr[slice_lo(c, ADDR_WIDTH) +: ADDR_WIDTH];
            req[c].wdata = bus.req_wdata[slice_lo(c, DATA_WIDTH) +: DATA_WIDTH];
            req[c].be    = bus.req_be[slice_lo(c, BE_W) +: BE_W];
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk (clk),
        .rst (reset),
        .req (bus.req_valid),
        .gnt (gnt)
    );

    assign bus.req_ready = gnt;
    assign fire          = |gnt;

    // Grant is one-hot, so an OR-style mux picks exactly one payload.
    always_comb begin
        sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
                sel = req[c];
            end
        end
    end

    assign in_range = ({1'b0, sel.addr} < DEPTH_LIM);
    assign idx      = sel.addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (fire && sel.op == OP_WRITE && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel.be[b]) begin
                    mem[idx][b*8 +: 8] <= sel.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= (fire && sel.op == OP_READ) ? gnt : '0;
            rsp_err_q   <= fire && sel.op == OP_READ && !in_range;
            wr_err_q    <= fire && sel.op == OP_WRITE && !in_range;
            // Data holds across idle and write cycles.
            if (fire && sel.op == OP_READ) begin
                rsp_data_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_control_ram_arb.sv
// Directed bench for control_ram_arb in three configurations (8b/2ch, 32b/2ch, 8b/3ch).
// Latency: n/a.
// Backpressure: n/a.
module tb_control_ram_arb;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    control_ram_arb_if #(.NUM_CH(2), .DATA_WIDTH(8),  .ADDR_WIDTH(32)) ia ();
    control_ram_arb_if #(.NUM_CH(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) ib ();
    control_ram_arb_if #(.NUM_CH(3), .DATA_WIDTH(8),  .ADDR_WIDTH(32)) ic ();

    control_ram_arb #(.DATA_WIDTH(8),  .ADDR_WIDTH(32), .DEPTH(256), .NUM_CH(2)) u_a (
        .clk(clk), .reset(reset), .bus(ia.slave));
    control_ram_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .NUM_CH(2)) u_b (
        .clk(clk), .reset(reset), .bus(ib.slave));
    control_ram_arb #(.DATA_WIDTH(8),  .ADDR_WIDTH(32), .DEPTH(256), .NUM_CH(3)) u_c (
        .clk(clk), .reset(reset), .bus(ic.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_a(input int ch, input logic v, input logic w, input logic [31:0] addr,
                         input logic [7:0] wd, input logic be);
        ia.req_valid[ch]         = v;
        ia.req_write[ch]         = w;
        ia.req_addr[ch*32 +: 32] = addr;
        ia.req_wdata[ch*8 +: 8]  = wd;
        ia.req_be[ch]            = be;
    endtask

    // Single granted op on instance A; returns just after the grant edge with valid dropped.
    task automatic op_a(input int ch, input logic w, input logic [31:0] addr,
                        input logic [7:0] wd, input logic be);
        set_a(ch, 1'b1, w, addr, wd, be);
        tick();
        ia.req_valid[ch] = 1'b0;
    endtask

    task automatic op_b(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be);
        ib.req_valid[0]     = 1'b1;
        ib.req_write[0]     = w;
        ib.req_addr[31:0]   = addr;
        ib.req_wdata[31:0]  = wd;
        ib.req_be[3:0]      = be;
        tick();
        ib.req_valid[0]     = 1'b0;
    endtask

    task automatic op_c(input int ch, input logic [31:0] addr, input logic [7:0] wd);
        ic.req_valid[ch]         = 1'b1;
        ic.req_write[ch]         = 1'b1;
        ic.req_addr[ch*32 +: 32] = addr;
        ic.req_wdata[ch*8 +: 8]  = wd;
        ic.req_be[ch]            = 1'b1;
        tick();
        ic.req_valid[ch]         = 1'b0;
    endtask

    logic [1:0] gseq2 [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [2:0] gseq3 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    logic [7:0] dseq3 [6] = '{8'h10, 8'h11, 8'h22, 8'h10, 8'h22, 8'h10};
    int cnt0, cnt1;

    initial begin
        ia.req_valid = '0; ia.req_write = '0; ia.req_addr = '0; ia.req_wdata = '0; ia.req_be = '0;
        ib.req_valid = '0; ib.req_write = '0; ib.req_addr = '0; ib.req_wdata = '0; ib.req_be = '0;
        ic.req_valid = '0; ic.req_write = '0; ic.req_addr = '0; ic.req_wdata = '0; ic.req_be = '0;

        #50;
        chk("rst_rsp_valid", ia.rsp_valid, 2'b00);
        chk("rst_rsp_data",  ia.rsp_data,  8'h00);
        chk("rst_rsp_err",   ia.rsp_err,   1'b0);
        chk("rst_wr_err",    ia.wr_err,    1'b0);
        #50 reset = 1'b0;
        tick();

        // Write then read back the same address on consecutive cycles.
        set_a(0, 1'b1, 1'b1, 32'h0, 8'h5A, 1'b1);
        settle();
        chk("t1_wr_ready", ia.req_ready, 2'b01);
        tick();
        set_a(0, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
        settle();
        chk("t1_rd_ready", ia.req_ready, 2'b01);
        chk("t1_wr_noerr", ia.wr_err, 1'b0);
        tick();
        ia.req_valid[0] = 1'b0;
        settle();
        chk("t1_rsp_valid", ia.rsp_valid, 2'b01);
        chk("t1_rsp_data",  ia.rsp_data,  8'h5A);
        chk("t1_rsp_err",   ia.rsp_err,   1'b0);
        tick();
        chk("t1_pulse", ia.rsp_valid, 2'b00);

        // be=0 write must not disturb the word.
        op_a(0, 1'b1, 32'h0, 8'hFF, 1'b0);
        op_a(0, 1'b0, 32'h0, 8'h00, 1'b0);
        settle();
        chk("be0_noop", ia.rsp_data, 8'h5A);
        op_a(0, 1'b1, 32'hFF, 8'h77, 1'b1);
        op_a(1, 1'b1, 32'h01, 8'hC3, 1'b1);

        // Both channels hold valid reads: grants alternate starting from ch0.
        cnt0 = 0;
        cnt1 = 0;
        set_a(0, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
        set_a(1, 1'b1, 1'b0, 32'h1, 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("t2_gnt%0d", k), ia.req_ready, gseq2[k]);
            if (k > 0) begin
                chk($sformatf("t2_rsp%0d", k - 1), ia.rsp_valid, gseq2[k-1]);
                chk($sformatf("t2_dat%0d", k - 1), ia.rsp_data, (gseq2[k-1] == 2'b01) ? 8'h5A : 8'hC3);
                cnt0 += int'(ia.rsp_valid[0]);
                cnt1 += int'(ia.rsp_valid[1]);
            end
            tick();
        end
        ia.req_valid = '0;
        settle();
        chk("t2_rsp5", ia.rsp_valid, gseq2[5]);
        chk("t2_dat5", ia.rsp_data, 8'hC3);
        cnt0 += int'(ia.rsp_valid[0]);
        cnt1 += int'(ia.rsp_valid[1]);
        chk("t2_cnt0", cnt0, 3);
        chk("t2_cnt1", cnt1, 3);

        // Out-of-range accesses, including a high address bit that truncation would hide.
        op_a(1, 1'b0, 32'h100, 8'h00, 1'b0);
        settle();
        chk("t4_rd_valid", ia.rsp_valid, 2'b10);
        chk("t4_rd_data",  ia.rsp_data,  8'h00);
        chk("t4_rd_err",   ia.rsp_err,   1'b1);
        op_a(0, 1'b0, 32'h1, 8'h00, 1'b0);
        settle();
        chk("t4_inr_data", ia.rsp_data, 8'hC3);
        chk("t4_inr_err",  ia.rsp_err,  1'b0);
        op_a(0, 1'b0, 32'h8000_0000, 8'h00, 1'b0);
        settle();
        chk("t4_hi_valid", ia.rsp_valid, 2'b01);
        chk("t4_hi_data",  ia.rsp_data,  8'h00);
        chk("t4_hi_err",   ia.rsp_err,   1'b1);
        op_a(1, 1'b1, 32'h1FF, 8'hEE, 1'b1);
        settle();
        chk("t4_wr_err",     ia.wr_err,    1'b1);
        chk("t4_wr_norsp",   ia.rsp_valid, 2'b00);
        tick();
        chk("t4_wr_err_off", ia.wr_err,    1'b0);
        op_a(0, 1'b0, 32'hFF, 8'h00, 1'b0);
        settle();
        chk("t4_alias_data", ia.rsp_data, 8'h77);
        chk("t4_alias_err",  ia.rsp_err,  1'b0);
        tick();
        settle();
        chk("idle_data",  ia.rsp_data,  8'h77);
        chk("idle_err",   ia.rsp_err,   1'b0);
        chk("idle_valid", ia.rsp_valid, 2'b00);

        // Reset during the response cycle of a ch0 read (which moved the pointer to 1).
        op_a(0, 1'b0, 32'h1, 8'h00, 1'b0);
        chk("t5_pre_valid", ia.rsp_valid, 2'b01);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", ia.rsp_valid, 2'b00);
        chk("t5_rst_data",  ia.rsp_data,  8'h00);
        settle();
        @(posedge clk);
        settle();
        reset = 1'b0;
        set_a(0, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
        set_a(1, 1'b1, 1'b0, 32'h1, 8'h00, 1'b0);
        #1;
        chk("t5_ptr0", ia.req_ready, 2'b01);
        tick();
        settle();
        chk("t5_rb0_valid", ia.rsp_valid, 2'b01);
        chk("t5_rb0_data",  ia.rsp_data,  8'h5A);
        chk("t5_gnt1",      ia.req_ready, 2'b10);
        tick();
        ia.req_valid = '0;
        settle();
        chk("t5_rb1_valid", ia.rsp_valid, 2'b10);
        chk("t5_rb1_data",  ia.rsp_data,  8'hC3);

        // 32-bit lanes: partial overwrite keeps the unselected bytes.
        op_b(1'b1, 32'h10, 32'hAABB_CCDD, 4'b1111);
        op_b(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        op_b(1'b0, 32'h10, 32'h0, 4'b0000);
        settle();
        chk("t3_valid", ib.rsp_valid, 2'b01);
        chk("t3_data",  ib.rsp_data,  32'hAA22_CC44);

        // Three channels: ch1 withdraws after its first grant.
        op_c(0, 32'h0, 8'h10);
        op_c(1, 32'h1, 8'h11);
        op_c(2, 32'h2, 8'h22);
        ic.req_write = '0;
        ic.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("t6_gnt%0d", k), ic.req_ready, gseq3[k]);
            if (k > 0) begin
                chk($sformatf("t6_rsp%0d", k - 1), ic.rsp_valid, gseq3[k-1]);
                chk($sformatf("t6_dat%0d", k - 1), ic.rsp_data, dseq3[k-1]);
            end
            tick();
            if (k == 1) begin
                ic.req_valid[1] = 1'b0;
            end
        end
        ic.req_valid = '0;
        settle();
        chk("t6_rsp5", ic.rsp_valid, gseq3[5]);
        chk("t6_dat5", ic.rsp_data,  dseq3[5]);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
